// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, classes,
// FSM states, mux select codes and ALU control encoding.
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } op_class_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_BUS     = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // funct7[5] only distinguishes SRAI among immediate ops; elsewhere it is immediate data
    function automatic logic [3:0] alu_ctrl(input op_class_e cls, input logic [2:0] f3,
                                            input logic f7b5);
        logic [3:0] res;
        res = ALU_ADD;
        case (cls)
            CLS_R:      res = {f7b5, f3};
            CLS_I:      res = {(f3 == 3'b101) & f7b5, f3};
            CLS_BRANCH: res = ALU_SUB;
            default:    res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory request/ready handshake between the control unit and the memory port.
interface multicycle_control_unit_if;
    logic memReq;
    logic memWe;
    logic addrSel;
    logic memReady;

    modport master (output memReq, output memWe, output addrSel, input memReady);
    modport slave  (input memReq, input memWe, input addrSel, output memReady);
endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational RV32I opcode classifier; unknown opcodes are flagged illegal.
module rv_opcode_decoder
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       illegal
);

    always_comb begin
        op_class = CLS_NOP;
        illegal  = 1'b0;
        case (opcode)
            OPC_OP:     op_class = CLS_R;
            OPC_OP_IMM: op_class = CLS_I;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_JALR:   op_class = CLS_JALR;
            OPC_LUI:    op_class = CLS_LUI;
            OPC_AUIPC:  op_class = CLS_AUIPC;
            default:    illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, bus
// timeout and illegal-opcode traps, retired-instruction counter.
module multicycle_control_unit
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT     = 16,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1,
    parameter int unsigned RET_W           = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_unit_if.master   bus,
    input  logic [31:0]                 inst,
    input  logic                        branchTaken,
    output logic                        irWrite,
    output logic                        pcWrite,
    output logic [1:0]                  pcSel,
    output logic                        aluSrcA,
    output logic                        aluSrcB,
    output logic [3:0]                  aluControl,
    output logic [2:0]                  brFunct3,
    output logic                        regWrite,
    output logic [1:0]                  wbSel,
    output logic                        trap,
    output logic [1:0]                  trapCause,
    output logic [RET_W-1:0]            instret
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    op_class_e        op_class_q, op_class_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             f7b5_q, f7b5_d;
    logic [1:0]       trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [RET_W-1:0] instret_q, instret_d;

    op_class_e dec_class;
    logic      dec_illegal;
    logic      retire;
    logic      waiting;
    logic      unused_inst_bits;

    rv_opcode_decoder u_decoder (
        .opcode   (inst[6:0]),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            op_class_q   <= CLS_NOP;
            funct3_q     <= '0;
            f7b5_q       <= 1'b0;
            trap_cause_q <= TRAP_NONE;
            wait_cnt_q   <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_class_q   <= op_class_d;
            funct3_q     <= funct3_d;
            f7b5_q       <= f7b5_d;
            trap_cause_q <= trap_cause_d;
            wait_cnt_q   <= wait_cnt_d;
            instret_q    <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_class_d   = op_class_q;
        funct3_d     = funct3_q;
        f7b5_d       = f7b5_q;
        trap_cause_d = trap_cause_q;
        wait_cnt_d   = wait_cnt_q;
        retire       = 1'b0;
        waiting      = 1'b0;

        bus.memReq  = 1'b0;
        bus.memWe   = 1'b0;
        bus.addrSel = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcSel       = PC_PLUS4;
        aluSrcA     = 1'b0;
        aluSrcB     = 1'b0;
        aluControl  = ALU_ADD;
        brFunct3    = '0;
        regWrite    = 1'b0;
        wbSel       = WB_ALU;
        trap        = 1'b0;
        trapCause   = TRAP_NONE;

        case (state_q)
            ST_FETCH: begin
                bus.memReq = 1'b1;
                if (bus.memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_DECODE: begin
                op_class_d = dec_class;
                funct3_d   = inst[14:12];
                f7b5_d     = inst[30];
                if (!dec_illegal) begin
                    state_d = ST_EXEC;
                end else if (TRAP_ON_ILLEGAL) begin
                    trap_cause_d = TRAP_ILLEGAL;
                    state_d      = ST_TRAP;
                end else begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                aluControl = alu_ctrl(op_class_q, funct3_q, f7b5_q);
                aluSrcA    = (op_class_q == CLS_JAL) || (op_class_q == CLS_AUIPC);
                aluSrcB    = (op_class_q != CLS_R) && (op_class_q != CLS_BRANCH);
                case (op_class_q)
                    CLS_BRANCH: begin
                        brFunct3 = funct3_q;
                        pcWrite  = branchTaken;
                        pcSel    = PC_TARGET;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                bus.memReq  = 1'b1;
                bus.addrSel = 1'b1;
                bus.memWe   = (op_class_q == CLS_STORE);
                if (bus.memReady) begin
                    if (op_class_q == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_WB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                state_d  = ST_FETCH;
                case (op_class_q)
                    CLS_LOAD: wbSel = WB_MEM;
                    CLS_LUI:  wbSel = WB_IMM;
                    CLS_JAL: begin
                        wbSel   = WB_PC4;
                        pcWrite = 1'b1;
                        pcSel   = PC_TARGET;
                    end
                    CLS_JALR: begin
                        wbSel   = WB_PC4;
                        pcWrite = 1'b1;
                        pcSel   = PC_JALR;
                    end
                    default:  wbSel = WB_ALU;
                endcase
            end
            ST_TRAP: begin
                trap      = 1'b1;
                trapCause = trap_cause_q;
            end
            default: state_d = ST_TRAP;
        endcase

        // The last allowed wait cycle traps only if memReady is still low then
        if (waiting && (MEM_TIMEOUT > 0)) begin
            if (wait_cnt_q == WAIT_LAST) begin
                trap_cause_d = TRAP_BUS;
                state_d      = ST_TRAP;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end

        instret_d = instret_q + RET_W'(retire);

        // Reset already forces FETCH; this blanks FETCH's request while rst_n is low
        if (!rst_n) begin
            bus.memReq  = 1'b0;
            bus.memWe   = 1'b0;
            bus.addrSel = 1'b0;
            irWrite     = 1'b0;
            pcWrite     = 1'b0;
            pcSel       = PC_PLUS4;
            aluSrcA     = 1'b0;
            aluSrcB     = 1'b0;
            aluControl  = ALU_ADD;
            brFunct3    = '0;
            regWrite    = 1'b0;
            wbSel       = WB_ALU;
            trap        = 1'b0;
            trapCause   = TRAP_NONE;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default build (A) plus a build
// with short timeout, illegal-as-NOP and 4-bit retire counter (B).
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        rst_a_n, br_a;
    logic [31:0] inst_a;
    logic        irw_a, pcw_a, srca_a, srcb_a, regw_a, trap_a;
    logic [1:0]  pcsel_a, wbsel_a, cause_a;
    logic [3:0]  aluc_a;
    logic [2:0]  brf3_a;
    logic [31:0] ret_a;

    logic        rst_b_n, br_b;
    logic [31:0] inst_b;
    logic        irw_b, pcw_b, srca_b, srcb_b, regw_b, trap_b;
    logic [1:0]  pcsel_b, wbsel_b, cause_b;
    logic [3:0]  aluc_b;
    logic [2:0]  brf3_b;
    logic [3:0]  ret_b;

    multicycle_control_unit_if mif_a ();
    multicycle_control_unit_if mif_b ();

    multicycle_control_unit dut_a (
        .clk (clk), .rst_n (rst_a_n), .bus (mif_a), .inst (inst_a), .branchTaken (br_a),
        .irWrite (irw_a), .pcWrite (pcw_a), .pcSel (pcsel_a), .aluSrcA (srca_a),
        .aluSrcB (srcb_a), .aluControl (aluc_a), .brFunct3 (brf3_a), .regWrite (regw_a),
        .wbSel (wbsel_a), .trap (trap_a), .trapCause (cause_a), .instret (ret_a)
    );

    multicycle_control_unit #(
        .MEM_TIMEOUT (4),
        .TRAP_ON_ILLEGAL (1'b0),
        .RET_W (4)
    ) dut_b (
        .clk (clk), .rst_n (rst_b_n), .bus (mif_b), .inst (inst_b), .branchTaken (br_b),
        .irWrite (irw_b), .pcWrite (pcw_b), .pcSel (pcsel_b), .aluSrcA (srca_b),
        .aluSrcB (srcb_b), .aluControl (aluc_b), .brFunct3 (brf3_b), .regWrite (regw_b),
        .wbSel (wbsel_b), .trap (trap_b), .trapCause (cause_b), .instret (ret_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_a();
        return 32'({mif_a.memReq, mif_a.memWe, mif_a.addrSel, irw_a, pcw_a, pcsel_a, srca_a,
                    srcb_a, aluc_a, brf3_a, regw_a, wbsel_a, trap_a, cause_a});
    endfunction

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BNE  = 32'h00209063;
    localparam logic [31:0] I_ILL  = 32'h00000000;

    logic [31:0] alu_inst [3] = '{32'h402081B3, 32'h4020D193, 32'h40008193};
    logic [3:0]  alu_exp  [3] = '{4'b1000, 4'b1101, 4'b0000};
    // inst, wbSel, pcWrite, pcSel and aluSrcA for jump/upper-immediate classes
    logic [31:0] j_inst [4] = '{32'h0000006F, 32'h000080E7, 32'h123451B7, 32'h00000197};
    logic [1:0]  j_wb   [4] = '{2'd2, 2'd2, 2'd3, 2'd0};
    logic        j_pcw  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  j_pcs  [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
    logic        j_srca [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        br_a = 1'b0; br_b = 1'b0;
        inst_a = I_ADD; inst_b = I_ILL;
        mif_a.memReady = 1'b0; mif_b.memReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mif_a.memReady = 1'b1;
        #1;
        check("reset_outputs_zero", outs_a(), 32'd0);
        check("reset_instret", ret_a, 32'd0);

        // ADD: F, D, E, WB
        rst_a_n = 1'b1;
        #1;
        check("add_fetch_req", 32'({mif_a.memReq, irw_a, pcw_a, pcsel_a, mif_a.addrSel}), 32'b11100_0);
        cyc();
        check("add_decode_idle", 32'({mif_a.memReq, irw_a, pcw_a, regw_a}), 32'd0);
        cyc();
        check("add_exec_aluc", 32'(aluc_a), 32'd0);
        check("add_exec_src", 32'({srca_a, srcb_a, regw_a}), 32'd0);
        cyc();
        check("add_wb", 32'({regw_a, wbsel_a}), 32'b100);
        check("add_wb_instret", ret_a, 32'd0);
        cyc();
        check("add_retired", ret_a, 32'd1);

        for (int i = 0; i < 3; i++) begin
            inst_a = alu_inst[i];
            cyc();
            cyc();
            check($sformatf("alu_ctrl_%0d", i), 32'(aluc_a), 32'(alu_exp[i]));
            cyc();
            cyc();
        end
        check("alu_instret", ret_a, 32'd4);

        // LW with three wait cycles in MEM
        inst_a = I_LW;
        cyc();
        cyc();
        mif_a.memReady = 1'b0;
        #1;
        check("lw_exec", 32'({aluc_a, srca_a, srcb_a}), 32'b0000_01);
        cyc();
        check("lw_mem1", 32'({mif_a.memReq, mif_a.addrSel, mif_a.memWe}), 32'b110);
        cyc();
        cyc();
        check("lw_mem3", 32'({mif_a.memReq, mif_a.addrSel}), 32'b11);
        cyc();
        mif_a.memReady = 1'b1;
        #1;
        check("lw_mem4", 32'({mif_a.memReq, regw_a}), 32'b10);
        cyc();
        check("lw_wb", 32'({regw_a, wbsel_a, mif_a.memReq}), 32'b1010);
        check("lw_wb_instret", ret_a, 32'd4);
        cyc();
        check("lw_retired", ret_a, 32'd5);

        // SW completes in MEM
        inst_a = I_SW;
        cyc();
        cyc();
        cyc();
        check("sw_mem", 32'({mif_a.memReq, mif_a.addrSel, mif_a.memWe, regw_a}), 32'b1110);
        cyc();
        check("sw_back_fetch", 32'({mif_a.memReq, mif_a.addrSel}), 32'b10);
        check("sw_retired", ret_a, 32'd6);

        // Branches resolve in EXEC
        inst_a = I_BEQ;
        cyc();
        cyc();
        br_a = 1'b1;
        #1;
        check("beq_taken", 32'({pcw_a, pcsel_a, brf3_a, regw_a, aluc_a}), 32'b1_01_000_0_1000);
        cyc();
        check("beq_next_fetch", 32'({irw_a, regw_a}), 32'b10);
        check("beq_retired", ret_a, 32'd7);
        inst_a = I_BNE;
        br_a = 1'b0;
        cyc();
        cyc();
        check("bne_not_taken", 32'({pcw_a, brf3_a, regw_a}), 32'b0_001_0);
        cyc();
        check("bne_retired", ret_a, 32'd8);

        for (int i = 0; i < 4; i++) begin
            inst_a = j_inst[i];
            cyc();
            cyc();
            check($sformatf("jmp_exec_srca_%0d", i), 32'(srca_a), 32'(j_srca[i]));
            cyc();
            check($sformatf("jmp_wb_%0d", i), 32'({regw_a, wbsel_a, pcw_a, pcsel_a}),
                  32'({1'b1, j_wb[i], j_pcw[i], j_pcs[i]}));
            cyc();
        end
        check("jmp_instret", ret_a, 32'd12);

        // Illegal opcode traps and stays trapped
        inst_a = I_ILL;
        cyc();
        check("ill_decode_no_trap", 32'(trap_a), 32'd0);
        cyc();
        check("ill_trap", 32'({trap_a, cause_a, mif_a.memReq}), 32'b1010);
        repeat (3) cyc();
        check("ill_trap_sticky", 32'({trap_a, cause_a, irw_a}), 32'b1010);
        check("ill_no_retire", ret_a, 32'd12);

        // Async reset in the middle of a MEM access
        rst_a_n = 1'b0;
        #1;
        rst_a_n = 1'b1;
        inst_a = I_LW;
        cyc();
        cyc();
        mif_a.memReady = 1'b0;
        cyc();
        check("rst_mem_pre", 32'({mif_a.memReq, mif_a.addrSel}), 32'b11);
        rst_a_n = 1'b0;
        #1;
        check("rst_mem_outputs", outs_a(), 32'd0);
        check("rst_mem_instret", ret_a, 32'd0);

        // B: illegal opcode retires as NOP
        rst_b_n = 1'b1;
        mif_b.memReady = 1'b1;
        #1;
        check("b_fetch", 32'(mif_b.memReq), 32'd1);
        cyc();
        cyc();
        check("b_nop_retire", 32'({trap_b, mif_b.memReq, ret_b}), 32'b0_1_0001);

        // B: timeout after exactly four FETCH cycles
        mif_b.memReady = 1'b0;
        #1;
        check("b_to_c1", 32'({trap_b, mif_b.memReq}), 32'b01);
        cyc();
        cyc();
        cyc();
        check("b_to_c4", 32'({trap_b, mif_b.memReq}), 32'b01);
        cyc();
        check("b_to_trap", 32'({trap_b, cause_b, mif_b.memReq}), 32'b1100);

        // B: memReady on the last allowed cycle wins
        rst_b_n = 1'b0;
        #1;
        rst_b_n = 1'b1;
        inst_b = I_ADD;
        #1;
        cyc();
        cyc();
        cyc();
        mif_b.memReady = 1'b1;
        #1;
        check("b_late_ready", 32'({irw_b, trap_b}), 32'b10);
        cyc();
        check("b_late_decode", 32'({trap_b, mif_b.memReq}), 32'b00);
        cyc();
        cyc();
        cyc();
        check("b_late_retired", 32'(ret_b), 32'd1);

        // B: 4-bit retire counter wraps
        inst_b = I_ILL;
        repeat (14) begin
            cyc();
            cyc();
        end
        check("b_ret_15", 32'(ret_b), 32'd15);
        cyc();
        cyc();
        check("b_ret_wrap", 32'({trap_b, ret_b}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
